// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one RAM port between the CPU sequencer and the
// program loader; every transfer is a fixed SETUP/STROBE/DONE access.
module mem_arbiter #(
  parameter int AW = 13,
  parameter int DW = 8
) (
  input  logic          CLK1,
  input  logic          RST,
  input  logic          CPU_REQ,
  input  logic          CPU_WE,
  input  logic [AW-1:0] CPU_ADDR,
  input  logic [DW-1:0] CPU_WDATA,
  output logic          CPU_GNT,
  output logic [DW-1:0] CPU_RDATA,
  output logic          CPU_RVALID,
  input  logic          LD_REQ,
  input  logic          LD_WE,
  input  logic [AW-1:0] LD_ADDR,
  input  logic [DW-1:0] LD_WDATA,
  output logic          LD_GNT,
  output logic [DW-1:0] LD_RDATA,
  output logic          LD_RVALID,
  output logic [AW-1:0] MEM_ADDR,
  output logic          MEM_RD,
  output logic          MEM_WD,
  output logic [DW-1:0] MEM_WDATA,
  input  logic [DW-1:0] MEM_RDATA,
  output logic          BUSY
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

  state_t        state;
  logic          last_ld;   // 1: loader won the most recent arbitration
  logic          lat_we;
  logic          lat_ld;

  logic          pick_ld;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;

  // Loader wins when it is alone, or on a tie when the CPU went last.
  always_comb begin
    pick_ld   = LD_REQ && (!CPU_REQ || !last_ld);
    req_we    = pick_ld ? LD_WE    : CPU_WE;
    req_addr  = pick_ld ? LD_ADDR  : CPU_ADDR;
    req_wdata = pick_ld ? LD_WDATA : CPU_WDATA;
  end

  always_ff @(posedge CLK1) begin
    if (!RST) begin
      state      <= IDLE;
      last_ld    <= 1'b1;
      lat_we     <= 1'b0;
      lat_ld     <= 1'b0;
      CPU_GNT    <= 1'b0;
      CPU_RDATA  <= '0;
      CPU_RVALID <= 1'b0;
      LD_GNT     <= 1'b0;
      LD_RDATA   <= '0;
      LD_RVALID  <= 1'b0;
      MEM_ADDR   <= '0;
      MEM_RD     <= 1'b0;
      MEM_WD     <= 1'b0;
      MEM_WDATA  <= '0;
      BUSY       <= 1'b0;
    end else begin
      CPU_GNT    <= 1'b0;
      LD_GNT     <= 1'b0;
      CPU_RVALID <= 1'b0;
      LD_RVALID  <= 1'b0;
      case (state)
        IDLE: begin
          if (CPU_REQ || LD_REQ) begin
            state     <= SETUP;
            lat_ld    <= pick_ld;
            last_ld   <= pick_ld;
            lat_we    <= req_we;
            CPU_GNT   <= !pick_ld;
            LD_GNT    <= pick_ld;
            BUSY      <= 1'b1;
            MEM_ADDR  <= req_addr;
            MEM_RD    <= !req_we;
            MEM_WD    <= 1'b0;
            MEM_WDATA <= req_we ? req_wdata : '0;
          end
        end
        SETUP: begin
          state  <= STROBE;
          MEM_WD <= lat_we;
        end
        STROBE: begin
          // Read data is captured on the edge that closes the strobe.
          state  <= DONE;
          MEM_RD <= 1'b0;
          MEM_WD <= 1'b0;
          if (!lat_we) begin
            if (lat_ld) begin
              LD_RDATA  <= MEM_RDATA;
              LD_RVALID <= 1'b1;
            end else begin
              CPU_RDATA  <= MEM_RDATA;
              CPU_RVALID <= 1'b1;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          BUSY      <= 1'b0;
          MEM_ADDR  <= '0;
          MEM_WDATA <= '0;
          CPU_RDATA <= '0;
          LD_RDATA  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: CPU read, loader write, contention,
// withdrawn request, mid-transfer input change and mid-transfer reset.
module tb_mem_arbiter;
  localparam int AW = 13;
  localparam int DW = 8;

  logic          CLK1 = 1'b0;
  logic          RST;
  logic          CPU_REQ, CPU_WE;
  logic [AW-1:0] CPU_ADDR;
  logic [DW-1:0] CPU_WDATA;
  logic          CPU_GNT, CPU_RVALID;
  logic [DW-1:0] CPU_RDATA;
  logic          LD_REQ, LD_WE;
  logic [AW-1:0] LD_ADDR;
  logic [DW-1:0] LD_WDATA;
  logic          LD_GNT, LD_RVALID;
  logic [DW-1:0] LD_RDATA;
  logic [AW-1:0] MEM_ADDR;
  logic          MEM_RD, MEM_WD, BUSY;
  logic [DW-1:0] MEM_WDATA, MEM_RDATA;

  logic [DW-1:0] ram [0:(1<<AW)-1];
  int n_cmp = 0;
  int n_err = 0;
  int wd_rise = 0;
  int wd_fall = 0;
  int rise0, fall0;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .CLK1(CLK1), .RST(RST),
    .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
    .CPU_GNT(CPU_GNT), .CPU_RDATA(CPU_RDATA), .CPU_RVALID(CPU_RVALID),
    .LD_REQ(LD_REQ), .LD_WE(LD_WE), .LD_ADDR(LD_ADDR), .LD_WDATA(LD_WDATA),
    .LD_GNT(LD_GNT), .LD_RDATA(LD_RDATA), .LD_RVALID(LD_RVALID),
    .MEM_ADDR(MEM_ADDR), .MEM_RD(MEM_RD), .MEM_WD(MEM_WD),
    .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA), .BUSY(BUSY)
  );

  always #5 CLK1 = ~CLK1;

  // RAM model: combinational read while RD is high, write on WD rising edge.
  assign MEM_RDATA = MEM_RD ? ram[MEM_ADDR] : '0;
  always @(posedge MEM_WD) begin
    wd_rise++;
    ram[MEM_ADDR] = MEM_WDATA;
  end
  always @(negedge MEM_WD) wd_fall++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK1);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, {CPU_GNT, CPU_RVALID, LD_GNT, LD_RVALID, MEM_RD, MEM_WD, BUSY}, 0);
    chk(tag, {MEM_ADDR, MEM_WDATA, CPU_RDATA, LD_RDATA}, 0);
  endtask

  // Invariants sampled on the falling edge while out of reset.
  always @(negedge CLK1) begin
    if (RST === 1'b1) begin
      chk("inv_rd_wd", MEM_RD & MEM_WD, 0);
      chk("inv_rvalid", CPU_RVALID & LD_RVALID, 0);
      chk("inv_gnt", CPU_GNT & LD_GNT, 0);
    end
  end

  initial begin
    for (int i = 0; i < (1<<AW); i++) ram[i] = '0;
    ram[13'h0A5] = 8'h3C;
    RST = 1'b0;
    CPU_REQ = 0; CPU_WE = 0; CPU_ADDR = '0; CPU_WDATA = '0;
    LD_REQ = 0;  LD_WE = 0;  LD_ADDR = '0;  LD_WDATA = '0;
    step(); step();
    chk_idle("reset_state");
    RST = 1'b1;
    step();
    chk_idle("idle_no_req");

    // CPU read of 0x0A5, with address change and LD pulse mid-transfer
    CPU_REQ = 1; CPU_WE = 0; CPU_ADDR = 13'h0A5;
    step();
    chk("rd_c1_gnt", {CPU_GNT, LD_GNT}, 2'b10);
    chk("rd_c1_addr", MEM_ADDR, 13'h0A5);
    chk("rd_c1_rd_wd_busy", {MEM_RD, MEM_WD, BUSY}, 3'b101);
    CPU_REQ = 0;
    step();
    chk("rd_c2_gnt", {CPU_GNT, LD_GNT}, 2'b00);
    chk("rd_c2_addr", MEM_ADDR, 13'h0A5);
    chk("rd_c2_rd_wd_busy", {MEM_RD, MEM_WD, BUSY}, 3'b101);
    CPU_ADDR = 13'h1FF;
    LD_REQ = 1;
    step();
    LD_REQ = 0;
    chk("rd_c3_rvalid", {CPU_RVALID, LD_RVALID}, 2'b10);
    chk("rd_c3_rdata", CPU_RDATA, 8'h3C);
    chk("rd_c3_addr_hold", MEM_ADDR, 13'h0A5);
    chk("rd_c3_rd_wd_busy", {MEM_RD, MEM_WD, BUSY}, 3'b001);
    CPU_REQ = 1;
    step();
    chk_idle("rd_c4_idle");
    chk("wd_no_pulse_read", wd_rise, 0);

    // Withdrawn LD request: only CPU is granted, at the new address
    step();
    chk("wdraw_gnt", {CPU_GNT, LD_GNT}, 2'b10);
    chk("wdraw_addr", MEM_ADDR, 13'h1FF);
    CPU_REQ = 0;
    step(); step();
    chk("wdraw_rvalid", {CPU_RVALID, LD_RVALID, CPU_RDATA}, {2'b10, 8'h00});
    step();
    chk_idle("wdraw_idle");

    // Loader write 0xA7 to 0x010
    rise0 = wd_rise;
    LD_REQ = 1; LD_WE = 1; LD_ADDR = 13'h010; LD_WDATA = 8'hA7;
    step();
    chk("wr_c1_gnt", {CPU_GNT, LD_GNT}, 2'b01);
    chk("wr_c1_bus", {MEM_ADDR, MEM_WDATA}, {13'h010, 8'hA7});
    chk("wr_c1_rd_wd_busy", {MEM_RD, MEM_WD, BUSY}, 3'b001);
    LD_REQ = 0;
    step();
    chk("wr_c2_wdata", MEM_WDATA, 8'hA7);
    chk("wr_c2_rd_wd", {MEM_RD, MEM_WD}, 2'b01);
    step();
    chk("wr_c3_bus", {MEM_ADDR, MEM_WDATA}, {13'h010, 8'hA7});
    chk("wr_c3_rd_wd_busy", {MEM_RD, MEM_WD, BUSY}, 3'b001);
    chk("wr_c3_rvalid", {CPU_RVALID, LD_RVALID}, 2'b00);
    step();
    chk_idle("wr_c4_idle");
    chk("wr_ram", ram[13'h010], 8'hA7);
    chk("wr_one_edge", wd_rise - rise0, 1);

    // Reset during STROBE of a loader write
    LD_REQ = 1; LD_WE = 1; LD_ADDR = 13'h010; LD_WDATA = 8'h5A;
    step();
    chk("rst_pre_gnt", LD_GNT, 1);
    LD_REQ = 0;
    step();
    chk("rst_pre_wd", MEM_WD, 1);
    rise0 = wd_rise;
    fall0 = wd_fall;
    RST = 0;
    step();
    chk_idle("rst_mid_1");
    step();
    chk_idle("rst_mid_2");
    chk("rst_wd_fall_once", wd_fall - fall0, 1);
    chk("rst_wd_no_rise", wd_rise - rise0, 0);

    // Contention straight out of reset: CPU, LD, CPU, LD, 4 cycles apart
    CPU_REQ = 1; CPU_WE = 0; CPU_ADDR = 13'h0A5;
    LD_REQ = 1;  LD_WE = 0;  LD_ADDR = 13'h010;
    RST = 1;
    for (int c = 1; c <= 16; c++) begin
      step();
      if (c % 4 == 1) begin
        if (((c / 4) % 2) == 0) chk($sformatf("cont_c%0d", c), {CPU_GNT, LD_GNT}, 2'b10);
        else                    chk($sformatf("cont_c%0d", c), {CPU_GNT, LD_GNT}, 2'b01);
      end else begin
        chk($sformatf("cont_c%0d", c), {CPU_GNT, LD_GNT}, 2'b00);
      end
      if (c == 3)  chk("cont_cpu_rdata", {CPU_RVALID, CPU_RDATA}, {1'b1, 8'h3C});
      if (c == 7)  chk("cont_ld_rdata", {LD_RVALID, LD_RDATA}, {1'b1, 8'h5A});
    end
    CPU_REQ = 0; LD_REQ = 0;
    step();
    chk_idle("final_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single program/data RAM port between two requesters:
  - the CPU sequencer (instruction fetch, operand read, STO write);
  - the program loader/debug port, which writes program images and reads back memory.
- Sits between both requesters and the RAM, and owns the RAM address, RD, WD and write-data lines.
- Arbitrates round-robin and runs every transfer as a fixed 3-cycle RAM access, with a WD rising edge for writes.

Parameters:
- AW, 13: RAM address width.
- DW, 8: RAM data width.

Ports:
- CLK1  in  1  system clock; all logic is on the rising edge.
- RST  in  1  synchronous, active-low reset.
- CPU_REQ  in  1  CPU requests one RAM transfer; held until CPU_GNT.
- CPU_WE  in  1  1 = write, 0 = read.
- CPU_ADDR  in  AW  transfer address.
- CPU_WDATA  in  DW  write data.
- CPU_GNT  out  1  one-cycle grant pulse.
- CPU_RDATA  out  DW  read data; valid while CPU_RVALID = 1.
- CPU_RVALID  out  1  one-cycle read-complete pulse.
- LD_REQ, LD_WE, LD_ADDR, LD_WDATA, LD_GNT, LD_RDATA, LD_RVALID: loader port, same directions, widths and meaning as the CPU_ set.
- MEM_ADDR  out  AW  RAM address.
- MEM_RD  out  1  RAM read enable.
- MEM_WD  out  1  RAM write strobe; the RAM writes on its rising edge.
- MEM_WDATA  out  DW  RAM write data.
- MEM_RDATA  in  DW  RAM read data.
- BUSY  out  1  a transfer is in progress.

Behaviour:
- All outputs are registered.
- States: IDLE, SETUP, STROBE, DONE.
- Reset (RST = 0 at a clock edge, from any state, including mid-transfer):
  - state <= IDLE; last_winner <= LD, so the CPU wins the first tie;
  - every output <= 0, including MEM_WD, so no spurious write edge occurs after reset;
  - latched request fields are cleared.
- IDLE:
  - Requests are sampled only in IDLE.
  - Only one requester high: it wins.
  - Both high: the requester not equal to last_winner wins; last_winner <= winner.
  - The edge that samples the request latches the winner's WE/ADDR/WDATA and enters SETUP.
  - No request: outputs stay 0.
- SETUP (first cycle after the sampling edge):
  - winner's GNT = 1, for this cycle only;
  - BUSY = 1; MEM_ADDR = latched address; MEM_RD = ~WE; MEM_WD = 0;
  - MEM_WDATA = latched data if write, else 0.
- STROBE:
  - MEM_ADDR, MEM_RD and MEM_WDATA hold their SETUP values; MEM_WD = WE.
  - For a read, MEM_RDATA is captured at the closing edge.
- DONE:
  - MEM_RD = 0 and MEM_WD = 0; for a write this is the 1->0 WD edge.
  - MEM_ADDR and MEM_WDATA hold for write hold time; BUSY = 1.
  - For a read: the winner's RDATA = captured data and RVALID = 1 for this cycle; the loser's RVALID stays 0.
  - Next state: IDLE.
- Leaving DONE: MEM_ADDR, MEM_WDATA, RDATA and BUSY return to 0 in IDLE.
- Timing per transfer:
  - latency from request sampled to RVALID is 3 cycles;
  - a new request is sampled no earlier than the IDLE cycle after DONE, giving 4 cycles per transfer.
- Requester rules:
  - A requester drops REQ in the cycle after it sees GNT. If REQ is still high in IDLE, that is a new request and is arbitrated normally.
  - REQ dropped before it is sampled is a withdrawn request; no GNT is issued.
  - Request inputs that change during SETUP, STROBE or DONE have no effect; only the latched values are used.
- Guaranteed invariants:
  - at most one GNT per transfer;
  - never both RVALIDs high;
  - MEM_RD and MEM_WD never high together;
  - MEM_WD is never high outside STROBE.
- With both REQs held high continuously, grants strictly alternate, so neither requester waits more than one transfer.

Test Plan:
- Reset mid-transfer: start an LD write to 0x010; drive RST = 0 during STROBE for 2 cycles -> from the next edge all outputs are 0, with MEM_WD 1->0 exactly once at reset. Release RST with both REQs high -> CPU granted first.
- CPU read: CPU_REQ = 1, CPU_WE = 0, CPU_ADDR = 0x0A5; RAM returns 0x3C -> CPU_GNT in cycle 1; MEM_ADDR = 0x0A5 and MEM_RD = 1 in cycles 1–2; MEM_WD = 0 throughout; CPU_RVALID = 1 with CPU_RDATA = 0x3C in cycle 3; BUSY high in cycles 1–3.
- LD write: LD_WE = 1, LD_ADDR = 0x010, LD_WDATA = 0xA7 -> MEM_WDATA = 0xA7 in cycles 1–3; MEM_WD = 1 only in cycle 2; MEM_RD = 0 throughout; LD_RVALID never asserts. A RAM model reads 0xA7 at 0x010.
- Contention: both REQs held high for 16 cycles after reset -> grant order CPU, LD, CPU, LD, with GNT pulses 4 cycles apart.
- Withdrawn request: LD_REQ pulsed for 1 cycle during a CPU STROBE -> no LD_GNT; the next IDLE with only CPU_REQ high grants the CPU.
- Input change mid-transfer: CPU_ADDR changed from 0x0A5 to 0x1FF during STROBE -> MEM_ADDR stays 0x0A5 through DONE.
